// File: rtl/tc_counter.sv
// tc_counter: loadable free-running up-counter; advances by STEP each clock
// and wraps modulo 2^WIDTH, or captures in when save is high.
`timescale 1ns/1ps
module tc_counter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    // Truncating the step to WIDTH bits makes the add wrap for free.
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb count_d = save ? in : count_q + STEP_W;
    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    assign out = count_q;
endmodule

// File: tb/tb_tc_counter.sv
// tb_tc_counter: directed and random checks of tc_counter (STEP=1 and STEP=3)
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_tc_counter;
    logic       clk = 1'b0;
    logic       rst, save;
    logic [7:0] din, out1, out3;
    int         m1, m3;
    int         vectors = 0, miscompares = 0;

    tc_counter #(.WIDTH(8), .STEP(1)) u1 (.clk(clk), .rst(rst), .save(save), .in(din), .out(out1));
    tc_counter #(.WIDTH(8), .STEP(3)) u3 (.clk(clk), .rst(rst), .save(save), .in(din), .out(out3));

    always #5 clk = ~clk;

    task automatic check(input string tag);
        vectors += 2;
        assert (out1 === 8'(m1)) else begin
            miscompares++;
            $error("FAIL %s step1: observed %02h expected %02h", tag, out1, 8'(m1));
        end
        assert (out3 === 8'(m3)) else begin
            miscompares++;
            $error("FAIL %s step3: observed %02h expected %02h", tag, out3, 8'(m3));
        end
    endtask

    // Apply inputs, let one rising edge pass, update the model, compare.
    task automatic tick(input logic s, input logic [7:0] d, input string tag);
        save = s;
        din  = d;
        @(posedge clk);
        #1;
        if (s) begin
            m1 = int'(d);
            m3 = int'(d);
        end else begin
            m1 = (m1 + 1) % 256;
            m3 = (m3 + 3) % 256;
        end
        check(tag);
    endtask

    // Drop reset between edges; the outputs must clear before any clock.
    task automatic reset_pulse(input string tag);
        save = 1'b1;
        din  = 8'h99;
        #2 rst = 1'b0;
        #1;
        m1 = 0;
        m3 = 0;
        check(tag);
        #1 rst = 1'b1;
        save = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        save = 1'b0;
        din  = 8'h00;
        m1   = 0;
        m3   = 0;
        #2 rst = 1'b0;
        #1 check("reset_fall");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 check("reset_hold");
        end
        save = 1'b1;
        din  = 8'h55;
        @(posedge clk);
        #1 check("reset_ignores_save");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, "free_count");
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h00, "load_zero");
        for (int i = 0; i < 3; i++)  tick(1'b0, 8'h00, "count_after_zero");
        tick(1'b1, 8'h80, "load_80");
        for (int i = 0; i < 3; i++)  tick(1'b0, 8'h00, "count_after_80");
        tick(1'b1, 8'hFE, "load_fe");
        for (int i = 0; i < 3; i++)  tick(1'b0, 8'h00, "wrap");
        tick(1'b1, 8'h30, "load_30");
        for (int i = 0; i < 7; i++)  tick(1'b0, 8'h00, "count_to_37");
        reset_pulse("async_mid_count");
        tick(1'b0, 8'h00, "after_reset");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) reset_pulse("rand_reset");
            else tick($urandom_range(0, 3) == 0, 8'($urandom), "rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
